// File: rtl/ibex_pkg.sv
// Shared enumerations for the ibex EX-stage multiply/divide sequencer.
package ibex_pkg;

  // RV32M operation class; signedness travels separately as two flags.
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  // Sequencer states: idle, 32 iteration steps, sign fix-up, result valid.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_ITER = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_seq_state_e;

endpackage

// File: rtl/ibex_md_seq.sv
// Iterative RV32M multiply/divide sequencer. Works on operand magnitudes with
// a 32-step shift-add multiply or restoring divide sharing one 33-bit
// add/sub, then applies sign fix-up and presents a registered result with a
// one-cycle valid pulse.
module ibex_md_seq
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  md_op_e      op_i,
  input  logic        signed_a_i,
  input  logic        signed_b_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  // Two's-complement negation helpers used by magnitude capture and fix-up.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Control state
  md_seq_state_e state;
  logic [4:0]    cnt;

  // Operation context latched at accept
  md_op_e        op_q;
  logic          neg_a;
  logic          neg_b;

  // Datapath: addend is |A| for multiply and |B| for divide.
  // MUL: {acc_hi, acc_lo} = {partial product, remaining multiplier bits}.
  // DIV: {acc_hi, acc_lo} = {partial remainder, quotient bits}.
  logic [31:0]   addend;
  logic [31:0]   acc_hi;
  logic [31:0]   acc_lo;

  // Accept decode on the incoming request
  logic          can_accept;
  logic          accept;
  logic          in_is_div;
  logic          in_div_zero;
  logic          in_neg_a;
  logic          in_neg_b;
  logic [31:0]   in_mag_a;
  logic [31:0]   in_mag_b;
  logic [31:0]   div_zero_result;

  assign can_accept      = (state == MD_IDLE) || (state == MD_DONE);
  assign accept          = req_i && !kill_i && can_accept;
  assign in_is_div       = (op_i == MD_OP_DIV) || (op_i == MD_OP_REM);
  assign in_div_zero     = in_is_div && (op_b_i == 32'd0);
  assign in_neg_a        = signed_a_i && op_a_i[31];
  assign in_neg_b        = signed_b_i && op_b_i[31];
  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  assign in_mag_a        = in_neg_a ? neg32(op_a_i) : op_a_i;
  assign in_mag_b        = in_neg_b ? neg32(op_b_i) : op_b_i;
  assign div_zero_result = (op_i == MD_OP_DIV) ? 32'hFFFF_FFFF : op_a_i;

  // Shared 33-bit adder/subtractor; the extra carry bit is the "no borrow"
  // flag for the divide trial subtraction.
  logic          is_div;
  logic          add_sub;
  logic [32:0]   add_x;
  logic [32:0]   add_y;
  logic [33:0]   add_res;
  logic          trial_ok;
  logic [31:0]   step_hi;
  logic [31:0]   step_lo;

  assign is_div = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

  // Operand selection for the shared adder and the next iteration state
  always_comb begin
    add_sub = 1'b0;
    add_x   = {1'b0, acc_hi};
    add_y   = 33'd0;
    if (is_div) begin
      add_sub = 1'b1;
      add_x   = {acc_hi, acc_lo[31]};
      add_y   = {1'b0, addend};
    end else if (acc_lo[0]) begin
      add_y   = {1'b0, addend};
    end
    add_res  = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)} + {33'd0, add_sub};
    trial_ok = add_res[33];
    if (is_div) begin
      // Shifted remainder minus divisor; restore on borrow.
      step_hi = trial_ok ? add_res[31:0] : add_x[31:0];
      step_lo = {acc_lo[30:0], trial_ok};
    end else begin
      // Shift the 33-bit sum and the multiplier word right by one.
      step_hi = add_res[32:1];
      step_lo = {add_res[0], acc_lo[31:1]};
    end
  end

  // Sign fix-up and result selection
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix;
  logic [31:0]   rem_fix;
  logic [31:0]   fix_result;

  assign prod_fix = (neg_a ^ neg_b) ? neg64({acc_hi, acc_lo}) : {acc_hi, acc_lo};
  assign quo_fix  = (neg_a ^ neg_b) ? neg32(acc_lo) : acc_lo;
  assign rem_fix  = neg_a ? neg32(acc_hi) : acc_hi;

  // Pick the word the operation returns
  always_comb begin
    unique case (op_q)
      MD_OP_MULL: fix_result = prod_fix[31:0];
      MD_OP_MULH: fix_result = prod_fix[63:32];
      MD_OP_DIV:  fix_result = quo_fix;
      default:    fix_result = rem_fix;
    endcase
  end

  // Sequencer FSM with registered busy/valid/result; kill beats everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= MD_IDLE;
      cnt      <= 5'd0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= 32'd0;
    end else if (kill_i) begin
      state    <= MD_IDLE;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      unique case (state)
        MD_IDLE, MD_DONE: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= MD_IDLE;
          if (req_i) begin
            if (in_div_zero) begin
              state    <= MD_DONE;
              valid_o  <= 1'b1;
              result_o <= div_zero_result;
            end else begin
              state    <= MD_ITER;
              cnt      <= 5'd31;
              busy_o   <= 1'b1;
            end
          end
        end
        MD_ITER: begin
          if (cnt == 5'd0) begin
            state <= MD_FIX;
          end else begin
            cnt   <= cnt - 5'd1;
          end
        end
        MD_FIX: begin
          state    <= MD_DONE;
          busy_o   <= 1'b0;
          valid_o  <= 1'b1;
          result_o <= fix_result;
        end
        default: begin
          state   <= MD_IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: load magnitudes on accept, step once per ITER cycle
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= op_i;
      neg_a <= in_neg_a;
      neg_b <= in_neg_b;
      if (in_is_div) begin
        addend <= in_mag_b;
        acc_hi <= 32'd0;
        acc_lo <= in_mag_a;
      end else begin
        addend <= in_mag_a;
        acc_hi <= 32'd0;
        acc_lo <= in_mag_b;
      end
    end else if (state == MD_ITER) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_ibex_md_seq.sv
// Self-checking bench for ibex_md_seq: a cycle-level behavioural model
// (arithmetic on wide integers plus accept/valid timing) is compared with the
// DUT on every cycle, and directed cases pin results to literal values.
module tb_ibex_md_seq;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        kill = 1'b0;
  md_op_e      op = MD_OP_MULL;
  logic        sa = 1'b0;
  logic        sb = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  ibex_md_seq dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .op_i      (op),
    .signed_a_i(sa),
    .signed_b_i(sb),
    .op_a_i    (a),
    .op_b_i    (b),
    .kill_i    (kill),
    .busy_o    (busy),
    .valid_o   (valid),
    .result_o  (result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic from the RV32M rules on sign-extended 64-bit values.
  function automatic logic [31:0] ref_md(input md_op_e o, input logic s_a, input logic s_b,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye, p;
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    if (o == MD_OP_MULL || o == MD_OP_MULH) begin
      xe = s_a ? {{32{x[31]}}, x} : {32'h0, x};
      ye = s_b ? {{32{y[31]}}, y} : {32'h0, y};
      p  = xe * ye;
      return (o == MD_OP_MULL) ? p[31:0] : p[63:32];
    end
    if (y == 32'd0) return (o == MD_OP_DIV) ? 32'hFFFF_FFFF : x;
    na = s_a & x[31];
    nb = s_b & y[31];
    ma = na ? 32'(-x) : x;
    mb = nb ? 32'(-y) : y;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = 32'(-q);
    if (na)      r = 32'(-r);
    return (o == MD_OP_DIV) ? q : r;
  endfunction

  // Model state: cycle index, busy window end, valid cycle, held result.
  int          cyc = 0;
  int          busy_end = -1;
  int          valid_cyc = -1;
  logic [31:0] pend = 32'd0;
  logic [31:0] cur = 32'd0;
  bit          armed = 1'b0;

  // Model update at each active edge from the inputs presented that cycle
  initial begin
    forever begin
      int c;
      @(posedge clk);
      c = cyc;
      if (rst) begin
        busy_end  = -1;
        valid_cyc = -1;
        cur       = 32'd0;
        armed     = 1'b1;
      end else if (kill) begin
        busy_end  = -1;
        valid_cyc = -1;
      end else if (req && c > busy_end) begin
        pend = ref_md(op, sa, sb, a, b);
        if ((op == MD_OP_DIV || op == MD_OP_REM) && b == 32'd0) begin
          valid_cyc = c + 1;
          busy_end  = -1;
        end else begin
          busy_end  = c + 33;
          valid_cyc = c + 34;
        end
      end
      cyc = c + 1;
      if (!rst && cyc == valid_cyc) cur = pend;
    end
  end

  // Per-cycle compare of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk($sformatf("valid@%0d", cyc), {31'd0, valid}, {31'd0, (cyc == valid_cyc)});
        chk($sformatf("busy@%0d", cyc), {31'd0, busy}, {31'd0, (cyc <= busy_end)});
        chk($sformatf("result@%0d", cyc), result, cur);
      end
    end
  end

  // Drive one request in the current cycle (call right after a negedge)
  task automatic issue(input md_op_e o, input logic s_a, input logic s_b,
                       input logic [31:0] x, input logic [31:0] y);
    op  = o;
    sa  = s_a;
    sb  = s_b;
    a   = x;
    b   = y;
    req = 1'b1;
  endtask

  // Count cycles after accept until valid; assumes we sit in accept+1
  task automatic wait_valid(output int n);
    n = 1;
    while (!valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input md_op_e o, input logic s_a, input logic s_b,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string nm);
    int n;
    int lat;
    @(negedge clk);
    issue(o, s_a, s_b, x, y);
    @(negedge clk);
    req = 1'b0;
    wait_valid(n);
    lat = ((o == MD_OP_DIV || o == MD_OP_REM) && y == 32'd0) ? 1 : 34;
    chk({nm, "_lat"}, n, lat);
    chk(nm, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] held;

    // Pin the reference arithmetic itself
    chk("model_mull", ref_md(MD_OP_MULL, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhsu", ref_md(MD_OP_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model_rem", ref_md(MD_OP_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;

    // Directed cases with literal expectations
    run_op(MD_OP_MULL, 1'b1, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mull_7x-3");
    run_op(MD_OP_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_op(MD_OP_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(MD_OP_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(MD_OP_DIV,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_-7/2");
    run_op(MD_OP_REM,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_-7/2");
    run_op(MD_OP_DIV,  1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, "divu");
    run_op(MD_OP_DIV,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(MD_OP_REM,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    run_op(MD_OP_DIV,  1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_op(MD_OP_REM,  1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_by0");
    run_op(MD_OP_DIV,  1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_by0");

    // Kill at c+10 together with a request, then a fresh MULL at c+11
    @(negedge clk);
    held = result;
    issue(MD_OP_MULL, 1'b0, 1'b0, 32'h1234, 32'h5678);
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    issue(MD_OP_MULL, 1'b0, 1'b0, 32'd9, 32'd9);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_result", result, held);
    issue(MD_OP_MULL, 1'b0, 1'b0, 32'd3, 32'd4);
    @(negedge clk);
    req = 1'b0;
    wait_valid(n);
    chk("after_kill_lat", n, 34);
    chk("after_kill_mull", result, 32'd12);

    // Reset at c+20 clears the result and returns to idle
    @(negedge clk);
    issue(MD_OP_DIV, 1'b0, 1'b0, 32'd1000, 32'd7);
    @(negedge clk);
    req = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    // Back-to-back accept in DONE
    run_op(MD_OP_MULL, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "b2b_first");
    issue(MD_OP_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    req = 1'b0;
    wait_valid(n);
    chk("b2b_lat", n, 34);
    chk("b2b_second", result, 32'hFFFF_FFFD);

    // Randomized traffic: overlapping requests, occasional kills and div-by-0
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      op   = md_op_e'(2'($urandom_range(0, 3)));
      sa   = 1'($urandom_range(0, 1));
      sb   = 1'($urandom_range(0, 1));
      a    = pick();
      b    = pick();
      req  = ($urandom_range(0, 3) == 0);
      kill = ($urandom_range(0, 119) == 0);
    end
    @(negedge clk);
    req  = 1'b0;
    kill = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
